// File: rtl/mips_mem_port_arbiter.sv
// mips_mem_port_arbiter
//   Shares one single-port unified memory between the IF stage (fetch) and
//   the MEM stage (load/store). Each access is granted in IDLE, runs for
//   WAIT_STATES+1 ACCESS cycles with the memory strobe held, and is completed
//   by a one-cycle ack in DONE with registered read data.
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//   Defined   : a starve counter forces an IF grant after STARVE_LIMIT
//               consecutive MEM grants made while IF was waiting.
//   Undefined : strict MEM priority, no counter.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   if_req_i / if_addr_i       fetch request (held until ack) and address
//   if_rdata_o / if_ack_o      fetched word and one-cycle completion pulse
//   if_stall_o                 if_req_i & ~if_ack_o
//   mem_req_i / mem_we_i       load/store request (held until ack), 1=store
//   mem_addr_i / mem_wdata_i   load/store address and store data
//   mem_rdata_o / mem_ack_o    load data and one-cycle completion pulse
//   mem_stall_o                mem_req_i & ~mem_ack_o
//   ram_addr_o, ram_re_o,
//   ram_we_o, ram_wdata_o      memory macro command (valid during ACCESS)
//   ram_rdata_i                combinational read data from the macro
//   busy_o                     high whenever an access is in progress
module mips_mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_ack_o,
  output logic                  if_stall_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_ack_o,
  output logic                  mem_stall_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_re_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  grant_mem, grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;
  logic       force_if;

  // IF has watched STARVE_LIMIT MEM grants go by: it takes this slot.
  assign force_if  = if_req_i && (starve_q == 4'(STARVE_LIMIT));
  assign grant_mem = mem_req_i && !force_if;
`else
  // The older instruction (MEM stage) always proceeds first.
  assign grant_mem = mem_req_i;
`endif
  assign grant_if = if_req_i && !grant_mem;

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_d    = starve_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          owner_d = OWN_MEM;
          addr_d  = mem_addr_i;
          we_d    = mem_we_i;
          wdata_d = mem_wdata_i;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_ACCESS;
`ifdef MEM_ARB_STARVE_GUARD_EN
          if (if_req_i && starve_q != 4'hF) starve_d = starve_q + 4'd1;
`endif
        end else if (grant_if) begin
          owner_d = OWN_IF;
          addr_d  = if_addr_i;
          we_d    = 1'b0;
          wdata_d = '0;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_ACCESS;
`ifdef MEM_ARB_STARVE_GUARD_EN
          starve_d = 4'd0;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Stores load the register too; mem_rdata_o is don't-care then.
          if (owner_q == OWN_IF) if_rdata_d  = ram_rdata_i;
          else                   mem_rdata_d = ram_rdata_i;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the read-data registers are reset as well, so both rdata outputs
      // read zero after reset instead of stale data from an abandoned access.
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= 4'd0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q    <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

  logic in_access;
  assign in_access = (state_q == S_ACCESS);

  // Memory command is only driven during ACCESS; strobes repeat every
  // ACCESS cycle, which the macro treats as idempotent.
  assign ram_addr_o  = in_access ? addr_q  : '0;
  assign ram_wdata_o = in_access ? wdata_q : '0;
  assign ram_re_o    = in_access && !we_q;
  assign ram_we_o    = in_access &&  we_q;

  assign if_ack_o    = (state_q == S_DONE) && (owner_q == OWN_IF);
  assign mem_ack_o   = (state_q == S_DONE) && (owner_q == OWN_MEM);
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_stall_o  = if_req_i  && !if_ack_o;
  assign mem_stall_o = mem_req_i && !mem_ack_o;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Self-checking bench for mips_mem_port_arbiter.
//   u_dut : WAIT_STATES=1, STARVE_LIMIT=2, backed by a 64-word bench RAM.
//   u_ws0 : WAIT_STATES=0, read data is a fixed function of the address.
// The reference model works at transaction level: expected latency is
// WAIT_STATES+2 cycles from request, loads return the last value stored to
// that word (ref_mem), and grant order under contention follows from the
// arbitration rules with plain arithmetic.
module tb_mips_mem_port_arbiter;

  localparam int WS  = 1;
  localparam int SL  = 2;
  localparam int LAT = WS + 2;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // u_dut signals
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata_o, mem_rdata_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        if_ack_o, if_stall_o, mem_ack_o, mem_stall_o;
  logic        ram_re_o, ram_we_o, busy_o;

  // u_ws0 signals
  logic        w0_if_req;
  logic [31:0] w0_if_addr;
  logic [31:0] w0_if_rdata, w0_mem_rdata, w0_ram_addr, w0_ram_wdata, w0_ram_rdata;
  logic        w0_if_ack, w0_if_stall, w0_mem_ack, w0_mem_stall;
  logic        w0_ram_re, w0_ram_we, w0_busy;

  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h2008_0005;  // instruction at byte address 0x40
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Bench memory macro: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else if (ram_we_o) begin
      ram[ram_addr_o[7:2]] <= ram_wdata_o;
    end
  end
  assign ram_rdata_i  = ram[ram_addr_o[7:2]];
  assign w0_ram_rdata = w0_ram_addr ^ 32'hA5A5_A5A5;

  mips_mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(WS), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o), .mem_stall_o(mem_stall_o),
    .ram_addr_o(ram_addr_o), .ram_re_o(ram_re_o), .ram_we_o(ram_we_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
  );

  mips_mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(0), .STARVE_LIMIT(SL)) u_ws0 (
    .clk(clk), .reset(reset),
    .if_req_i(w0_if_req), .if_addr_i(w0_if_addr), .if_rdata_o(w0_if_rdata),
    .if_ack_o(w0_if_ack), .if_stall_o(w0_if_stall),
    .mem_req_i(1'b0), .mem_we_i(1'b0), .mem_addr_i(32'h0), .mem_wdata_i(32'h0),
    .mem_rdata_o(w0_mem_rdata), .mem_ack_o(w0_mem_ack), .mem_stall_o(w0_mem_stall),
    .ram_addr_o(w0_ram_addr), .ram_re_o(w0_ram_re), .ram_we_o(w0_ram_we),
    .ram_wdata_o(w0_ram_wdata), .ram_rdata_i(w0_ram_rdata), .busy_o(w0_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on an idle u_dut and observes it until its ack.
  task automatic run_single(input bit is_mem, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output int strobes,
                            output logic [31:0] rdata, output bit other_ack, output bit timed_out);
    int start;
    bit done;
    lat = -1; strobes = 0; rdata = '0; other_ack = 0; done = 0;
    if (is_mem) begin
      mem_req = 1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1; if_addr = addr;
    end
    start = cyc;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if ((we ? ram_we_o : ram_re_o) && !(we ? ram_re_o : ram_we_o) &&
          ram_addr_o == addr && (!we || ram_wdata_o == wdata)) strobes++;
      if (is_mem ? if_ack_o : mem_ack_o) other_ack = 1;
      if (is_mem ? mem_ack_o : if_ack_o) begin
        lat   = cyc - start;
        rdata = is_mem ? mem_rdata_o : if_rdata_o;
        done  = 1;
      end
    end
    timed_out = !done;
    tick();
    if_req = 0; mem_req = 0; mem_we = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (busy_o !== 1'b0 || if_ack_o !== 1'b0 || mem_ack_o !== 1'b0 || ram_re_o !== 1'b0 ||
        ram_we_o !== 1'b0 || ram_addr_o !== 32'h0 || ram_wdata_o !== 32'h0 ||
        if_rdata_o !== 32'h0 || mem_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b ack=%b/%b re=%b we=%b addr=%h wd=%h rd=%h/%h, required all 0",
               busy_o, if_ack_o, mem_ack_o, ram_re_o, ram_we_o, ram_addr_o, ram_wdata_o, if_rdata_o, mem_rdata_o);
    end
    if_req = 1;
    #1;
    n_checks++;
    if (if_stall_o !== 1'b1 || mem_stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: if_stall=%b mem_stall=%b, required 1 0", if_stall_o, mem_stall_o);
    end
    if_req = 0;
  endtask

  task automatic test_fetch();
    int lat, st; logic [31:0] rd; bit oa, to;
    run_single(0, 0, 32'h0000_0040, 32'h0, lat, st, rd, oa, to);
    n_checks++;
    if (to || lat !== LAT || st !== WS + 1 || rd !== 32'h2008_0005 || oa) begin
      n_fail++;
      $display("FAIL fetch: timeout=%b lat=%0d re_cycles=%0d rdata=%h other_ack=%b, required 0 %0d %0d 20080005 0",
               to, lat, st, rd, oa, LAT, WS + 1);
    end
  endtask

  task automatic test_store();
    int lat, st; logic [31:0] rd; bit oa, to;
    run_single(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, lat, st, rd, oa, to);
    ref_mem[4] = 32'hDEAD_BEEF;
    n_checks++;
    if (to || lat !== LAT || st !== WS + 1 || oa) begin
      n_fail++;
      $display("FAIL store: timeout=%b lat=%0d we_cycles=%0d if_ack_seen=%b, required 0 %0d %0d 0",
               to, lat, st, oa, LAT, WS + 1);
    end
    run_single(0, 0, 32'h0000_0010, 32'h0, lat, st, rd, oa, to);
    n_checks++;
    if (to || rd !== ref_mem[4]) begin
      n_fail++;
      $display("FAIL store_readback: timeout=%b rdata=%h, required %h", to, rd, ref_mem[4]);
    end
  endtask

  task automatic test_both();
    int start, mem_lat, if_lat, stall_err, dual;
    mem_lat = -1; if_lat = -1; stall_err = 0; dual = 0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h80; if_req = 1; if_addr = 32'h84;
    start = cyc;
    for (int k = 0; k < 40 && (mem_lat < 0 || if_lat < 0); k++) begin
      @(negedge clk);
      if (if_ack_o && mem_ack_o) dual++;
      if (if_lat < 0 && !if_ack_o && if_stall_o !== 1'b1) stall_err++;
      if (mem_ack_o) mem_lat = cyc - start;
      if (if_ack_o)  if_lat  = cyc - start;
      tick();
      if (mem_lat >= 0) mem_req = 0;
      if (if_lat >= 0)  if_req = 0;
    end
    n_checks++;
    if (mem_lat !== LAT || if_lat !== 2 * LAT + 1) begin
      n_fail++;
      $display("FAIL both_order: mem_ack at +%0d if_ack at +%0d, required +%0d +%0d",
               mem_lat, if_lat, LAT, 2 * LAT + 1);
    end
    n_checks++;
    if (stall_err != 0 || dual != 0) begin
      n_fail++;
      $display("FAIL both_stall: stall_low_cycles=%0d dual_ack_cycles=%0d, required 0 0", stall_err, dual);
    end
    if_req = 0; mem_req = 0;
  endtask

  task automatic test_reset_mid();
    int lat, st; logic [31:0] rd; bit oa, to;
    int acks;
    if_req = 1; if_addr = 32'h40;
    tick();  // grant edge: now in the first ACCESS cycle
    n_checks++;
    if (busy_o !== 1'b1 || ram_re_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_access: busy=%b re=%b, required 1 1", busy_o, ram_re_o);
    end
    reset = 1;
    tick();
    reset = 0; if_req = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    n_checks++;
    if (busy_o !== 1'b0 || ram_re_o !== 1'b0 || ram_we_o !== 1'b0 || if_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy=%b re=%b we=%b ack=%b, required 0 0 0 0",
               busy_o, ram_re_o, ram_we_o, if_ack_o);
    end
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if_ack_o || mem_ack_o || busy_o) acks++;
    end
    tick();
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL reset_mid_noack: ack_or_busy_cycles=%0d, required 0", acks);
    end
    run_single(0, 0, 32'h40, 32'h0, lat, st, rd, oa, to);
    n_checks++;
    if (to || lat !== LAT || rd !== 32'h2008_0005) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: timeout=%b lat=%0d rdata=%h, required 0 %0d 20080005", to, lat, rd, LAT);
    end
  endtask

  task automatic test_random();
    int lat, st; logic [31:0] rd, a, wd; bit oa, to, is_mem, we;
    int idx;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0:       begin is_mem = 0; we = 0; end
        1:       begin is_mem = 1; we = 0; end
        default: begin is_mem = 1; we = 1; end
      endcase
      idx = $urandom_range(0, 63);
      a   = 32'(idx) << 2;
      wd  = $urandom;
      run_single(is_mem, we, a, wd, lat, st, rd, oa, to);
      n_checks++;
      if (to || lat !== LAT || st !== WS + 1 || oa) begin
        n_fail++;
        $display("FAIL random_timing[%0d]: mem=%b we=%b timeout=%b lat=%0d strobes=%0d other_ack=%b, required 0 %0d %0d 0",
                 n, is_mem, we, to, lat, st, oa, LAT, WS + 1);
      end
      if (we) begin
        ref_mem[idx] = wd;
      end else begin
        n_checks++;
        if (rd !== ref_mem[idx]) begin
          n_fail++;
          $display("FAIL random_data[%0d]: addr=%h rdata=%h, required %h", n, a, rd, ref_mem[idx]);
        end
      end
    end
  endtask

  task automatic test_starve();
    bit order [6];
    bit exp_if;
    int got;
    got = 0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h0; if_req = 1; if_addr = 32'h4;
    for (int k = 0; k < 60 && got < 6; k++) begin
      @(negedge clk);
      if (if_ack_o)  begin order[got] = 1; got++; end
      else if (mem_ack_o) begin order[got] = 0; got++; end
    end
    tick();
    mem_req = 0; if_req = 0;
    n_checks++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL starve_count: acks=%0d, required 6", got);
    end
    for (int k = 0; k < got; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if = (k % (SL + 1)) == SL;
`else
      exp_if = 0;
`endif
      n_checks++;
      if (order[k] !== exp_if) begin
        n_fail++;
        $display("FAIL starve_order[%0d]: granted %s, required %s", k,
                 order[k] ? "IF" : "MEM", exp_if ? "IF" : "MEM");
      end
    end
    repeat (WS + 4) tick();
  endtask

  task automatic test_ws0();
    int ack_cyc [3];
    logic [31:0] exp_rd [3];
    int got, re_cnt, start;
    bit bad_data;
    got = 0; re_cnt = 0; bad_data = 0;
    w0_if_req = 1; w0_if_addr = 32'h100;
    start = cyc;
    for (int k = 0; k < 30 && got < 3; k++) begin
      @(negedge clk);
      if (w0_ram_re) re_cnt++;
      if (w0_if_ack) begin
        ack_cyc[got] = cyc;
        exp_rd[got]  = w0_if_addr ^ 32'hA5A5_A5A5;
        if (w0_if_rdata !== exp_rd[got]) bad_data = 1;
        got++;
        tick();
        w0_if_addr = w0_if_addr + 32'h4;
      end
    end
    w0_if_req = 0;
    n_checks++;
    if (got != 3 || ack_cyc[0] - start != 2) begin
      n_fail++;
      $display("FAIL ws0_latency: acks=%0d first_at=+%0d, required 3 +2", got, ack_cyc[0] - start);
    end
    n_checks++;
    if (got == 3 && (ack_cyc[1] - ack_cyc[0] != 3 || ack_cyc[2] - ack_cyc[1] != 3)) begin
      n_fail++;
      $display("FAIL ws0_spacing: gaps=%0d,%0d, required 3,3", ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
    end
    n_checks++;
    if (bad_data || re_cnt != 3) begin
      n_fail++;
      $display("FAIL ws0_access: bad_rdata=%b re_cycles=%0d, required 0 3", bad_data, re_cnt);
    end
    tick();
  endtask

  initial begin
    reset = 1;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    w0_if_req = 0; w0_if_addr = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (3) tick();
    test_reset();
    reset = 0;
    tick();
    test_fetch();
    test_store();
    test_both();
    test_reset_mid();
    test_random();
    test_starve();
    test_ws0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
